// File: rtl/rfio_pkg.sv
// Shared constants and helpers for the rf1/rf0 host I/O bridge.
// The optional error counters are enabled with RFIO_ERR_CNT_EN (see rf_io_bridge.sv).
package rfio_pkg;

  localparam logic [1:0] ADDR_RF0 = 2'd0;
  localparam logic [1:0] ADDR_RF1 = 2'd1;

  // Pointer width for a power-of-two FIFO depth, e.g. 4 -> 2.
  function automatic int unsigned ptr_width(input int unsigned depth);
    int unsigned w;
    w = 1;
    for (int unsigned i = 1; i < 32; i++) begin
      if ((32'd1 << i) < depth) w = i + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/rfio_fifo.sv
// Synchronous FIFO with zero-latency head output. PUSH_ON_FULL_POP selects whether
// a push into a full FIFO is accepted when a pop completes in the same cycle.
module rfio_fifo
  import rfio_pkg::*;
#(
  parameter int unsigned WIDTH            = 8,
  parameter int unsigned DEPTH            = 4,
  parameter bit          PUSH_ON_FULL_POP = 1'b0
) (
  input  logic             CLK,
  input  logic             RSTN,
  input  logic             PUSH,
  input  logic             POP,
  input  logic [WIDTH-1:0] DIN,
  output logic [WIDTH-1:0] DOUT,
  output logic             FULL,
  output logic             EMPTY
);

  localparam int unsigned     PW       = ptr_width(DEPTH);
  localparam logic [PW:0]     FULL_CNT = (PW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wptr;
  logic [PW-1:0]    rptr;
  logic [PW:0]      count;
  logic             pop_ok;
  logic             push_ok;

  assign EMPTY   = (count == '0);
  assign FULL    = (count == FULL_CNT);
  assign pop_ok  = POP && !EMPTY;
  assign push_ok = PUSH && (!FULL || (PUSH_ON_FULL_POP && pop_ok));

  // Empty FIFO presents zero rather than a stale slot.
  assign DOUT = EMPTY ? '0 : mem[rptr];

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push_ok) wptr <= wptr + PW'(1);
      if (pop_ok)  rptr <= rptr + PW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + (PW+1)'(1);
        2'b01:   count <= count - (PW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // On a full push+pop, wptr equals rptr; the head is read before the edge overwrites it.
  always_ff @(posedge CLK) begin
    if (push_ok) mem[wptr] <= DIN;
  end

endmodule

// File: rtl/rf_io_bridge.sv
// Host-side bridge: external stream -> core rf1, core rf0 writes -> external stream.
// Define RFIO_ERR_CNT_EN to add saturating OVF_CNT/UNF_CNT error counters.
module rf_io_bridge
  import rfio_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             CLK,
  input  logic             RSTN,
  input  logic [1:0]       ADDR,
  input  logic             WEN,
  input  logic [WIDTH-1:0] WDATA,
  input  logic             RF1_RD,
  output logic [WIDTH-1:0] RF1DATA,
  output logic             RF1_AVAIL,
  input  logic [WIDTH-1:0] IN_DATA,
  input  logic             IN_VALID,
  output logic             IN_READY,
  output logic [WIDTH-1:0] OUT_DATA,
  output logic             OUT_VALID,
`ifdef RFIO_ERR_CNT_EN
  output logic [7:0]       OVF_CNT,
  output logic [7:0]       UNF_CNT,
`endif
  input  logic             OUT_READY
);

  logic [WIDTH-1:0] in_head;
  logic             in_full;
  logic             in_empty;
  logic [WIDTH-1:0] hold_q;

  logic             out_full;
  logic             out_empty;
  logic             out_wr;
  logic             out_pop;
  logic             out_push;

  rfio_fifo #(
    .WIDTH            (WIDTH),
    .DEPTH            (DEPTH),
    .PUSH_ON_FULL_POP (1'b0)
  ) u_in_fifo (
    .CLK   (CLK),
    .RSTN  (RSTN),
    .PUSH  (IN_VALID),
    .POP   (RF1_RD),
    .DIN   (IN_DATA),
    .DOUT  (in_head),
    .FULL  (in_full),
    .EMPTY (in_empty)
  );

  assign IN_READY  = !in_full;
  assign RF1_AVAIL = !in_empty;
  assign RF1DATA   = in_empty ? hold_q : in_head;

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      hold_q <= '0;
    end else if (RF1_RD && !in_empty) begin
      hold_q <= in_head;
    end
  end

  assign out_wr   = WEN && (ADDR == ADDR_RF0);
  assign out_pop  = OUT_READY && !out_empty;
  // Gated here too so the drop condition is explicit; the FIFO applies the same rule.
  assign out_push = out_wr && (!out_full || out_pop);

  rfio_fifo #(
    .WIDTH            (WIDTH),
    .DEPTH            (DEPTH),
    .PUSH_ON_FULL_POP (1'b1)
  ) u_out_fifo (
    .CLK   (CLK),
    .RSTN  (RSTN),
    .PUSH  (out_push),
    .POP   (OUT_READY),
    .DIN   (WDATA),
    .DOUT  (OUT_DATA),
    .FULL  (out_full),
    .EMPTY (out_empty)
  );

  assign OUT_VALID = !out_empty;

`ifdef RFIO_ERR_CNT_EN
  logic ovf_evt;
  logic unf_evt;

  assign ovf_evt = out_wr && !out_push;
  assign unf_evt = RF1_RD && in_empty;

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      OVF_CNT <= '0;
      UNF_CNT <= '0;
    end else begin
      if (ovf_evt && (OVF_CNT != '1)) OVF_CNT <= OVF_CNT + 8'd1;
      if (unf_evt && (UNF_CNT != '1)) UNF_CNT <= UNF_CNT + 8'd1;
    end
  end
`endif

endmodule

// File: doc/rf_io_bridge.md
# rf_io_bridge

Host-side I/O bridge for the 8-bit simple core's register file. It is the other end of the rf1/rf0 I/O mapping: it drives the core's read-only input register rf1 from an external valid/ready stream, and captures every core write to rf0 into an output valid/ready stream. It sits between the core top level and the board/SoC I/O, with one small FIFO per direction.

## Interface
Parameters:
- WIDTH, 8, data width; matches the core register width.
- DEPTH, 4, entries per FIFO; power of two, at least 2.

Ports:
- CLK  in  1  core clock.
- RSTN  in  1  asynchronous active-low reset.
- ADDR  in  2  core register-file address.
- WEN  in  1  core register-file write enable.
- WDATA  in  WIDTH  core register-file write data.
- RF1_RD  in  1  one-cycle pulse from the core when an instruction consumes rf1.
- RF1DATA  out  WIDTH  value presented to the core as rf1.
- RF1_AVAIL  out  1  input FIFO non-empty.
- IN_DATA  in  WIDTH  external input data.
- IN_VALID  in  1  external input valid.
- IN_READY  out  1  input FIFO can accept a word.
- OUT_DATA  out  WIDTH  captured rf0 write at the output FIFO head.
- OUT_VALID  out  1  output FIFO non-empty.
- OUT_READY  in  1  external consumer accepts OUT_DATA.

## Operation
- Reset: both FIFOs empty, pointers 0, hold register 0. Outputs are RF1DATA=0, RF1_AVAIL=0, IN_READY=1, OUT_VALID=0, OUT_DATA=0.
- Input push: IN_VALID && IN_READY writes IN_DATA. IN_READY = !in_full. A push is refused when the FIFO is full, even if RF1_RD pops in the same cycle.
- RF1DATA: the input FIFO head when non-empty. When empty, it is the hold register, which holds the last popped value.
- RF1_RD when non-empty: pops the head and loads it into the hold register.
- RF1_RD when empty: no pop and no pointer change. This is an underflow event.
- Simultaneous push and pop on a non-empty, non-full input FIFO: the count is unchanged.
- Output capture: WEN && ADDR==RF0 pushes WDATA. The core is never stalled.
- Output capture when the output FIFO is full: if OUT_READY && OUT_VALID in the same cycle, the pop and push both complete and the count stays at DEPTH. Otherwise the write is dropped (overflow event) and the FIFO contents are unchanged.
- Output pop: OUT_VALID && OUT_READY. OUT_DATA is the head; when empty it is 0.
- Writes to ADDR 1–3 are ignored.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH. The count is log2(DEPTH)+1 bits.

## Timing
- Every state change happens on the rising edge of CLK. RSTN asserts asynchronously and deasserts synchronously (external synchronizer).
- Input latency: a word accepted in cycle n is visible on RF1DATA and RF1_AVAIL in cycle n+1 if the FIFO was empty.
- Output latency: an rf0 write in cycle n gives OUT_VALID=1 with OUT_DATA=WDATA in cycle n+1.
- The FIFOs use no combinational paths from IN_VALID to IN_READY or from OUT_READY to OUT_VALID.
- Reset asserted mid-transfer discards all FIFO contents immediately.

## Configuration
- RFIO_ERR_CNT_EN defined:
  - Adds outputs OVF_CNT[7:0] and UNF_CNT[7:0].
  - These are saturating counters (stop at 8'hFF) for output overflow drops and rf1 underflow reads.
  - Both reset to 0.
- RFIO_ERR_CNT_EN undefined: the counters and their ports are absent. Drops and underflows are silent.

## Structure
- Package rfio_pkg:
  - ADDR_RF0=2'd0 and ADDR_RF1=2'd1.
  - A function returning the pointer width from DEPTH.
- Sub-module rfio_fifo (WIDTH, DEPTH):
  - Synchronous FIFO with push, pop, full, empty, and a head output.
  - The push-when-full-with-pop behaviour is selectable by parameter (input side refuses, output side accepts).
  - Instantiated twice.
- The top level holds the rf0 write decode, the RF1DATA hold register and the optional error counters.

## Test plan
- Reset, then 4 input words 0x11,0x22,0x33,0x44 with no RF1_RD:
  - IN_READY=0 after the 4th word; a 5th word 0x55 is refused.
  - RF1DATA=0x11.
- Pulse RF1_RD 5 times on the full FIFO: RF1DATA steps 0x22,0x33,0x44, then holds 0x44. The 5th pulse is an underflow (UNF_CNT=1 when enabled).
- Core writes 0xA5 to ADDR 0, then 0x5A to ADDR 2: OUT_VALID the next cycle with OUT_DATA=0xA5; only one entry is queued.
- OUT_READY=0 and 6 rf0 writes 0x01..0x06: FIFO holds 0x01..0x04 and OVF_CNT=2. With OUT_READY=1 and a write in the same full cycle, the count stays 4 and there are no drops.
- Simultaneous push and pop on both FIFOs for 20 cycles with wrapping pointers: data order is preserved end to end.
- RSTN asserted mid-stream with both FIFOs partially full: all outputs return to their reset values asynchronously, before the next CLK edge.
